// File: rtl/mwrite_queue.sv
// In-order store queue between the memory-access write stage and the data-memory write port.
// It also flags read-after-write hazards against pending and incoming stores.
module mwrite_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             MEMR_MEM_W_VALID,
  input  logic [31:0]      MEMR_MEM_W_ADDR,
  input  logic [3:0]       MEMR_MEM_W_STRB,
  input  logic [31:0]      MEMR_MEM_W_DATA,
  output logic             MEMR_MEM_W_READY,
  output logic             MEM_W_VALID,
  output logic [31:0]      MEM_W_ADDR,
  output logic [3:0]       MEM_W_STRB,
  output logic [31:0]      MEM_W_DATA,
  input  logic             MEM_W_READY,
  input  logic [31:0]      HZ_ADDR,
  output logic             HZ_HIT,
  output logic             EMPTY,
  output logic [PTR_W:0]   COUNT
);

  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             enq, deq;
  logic             unused_hz_lsb;

  assign MEMR_MEM_W_READY = (count_q != FULL_CNT);
  assign MEM_W_VALID      = (count_q != '0);
  assign EMPTY            = (count_q == '0);
  assign COUNT            = count_q;

  // Zero-strobe requests complete the handshake but are never stored.
  assign enq = MEMR_MEM_W_VALID && MEMR_MEM_W_READY && (MEMR_MEM_W_STRB != 4'b0000);
  assign deq = MEM_W_VALID && MEM_W_READY;

  // Head is masked while empty so the memory bus reads zero after reset.
  assign head       = MEM_W_VALID ? mem_q[rp_q] : '0;
  assign MEM_W_ADDR = head.addr;
  assign MEM_W_STRB = head.strb;
  assign MEM_W_DATA = head.data;

  assign unused_hz_lsb = ^HZ_ADDR[1:0];

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (enq) wp_d = wp_q + PTR_W'(1);
    if (deq) rp_d = rp_q + PTR_W'(1);
    case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset; occupancy is tracked by count alone.
  always_ff @(posedge CLK) begin
    if (enq) begin
      mem_q[wp_q] <= '{addr: MEMR_MEM_W_ADDR, strb: MEMR_MEM_W_STRB, data: MEMR_MEM_W_DATA};
    end
  end

  // Word-address match against the incoming request and every occupied slot.
  always_comb begin
    HZ_HIT = enq && (MEMR_MEM_W_ADDR[31:2] == HZ_ADDR[31:2]);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(PTR_W'(PTR_W'(i) - rp_q)) < count_q) &&
          (mem_q[i].addr[31:2] == HZ_ADDR[31:2])) begin
        HZ_HIT = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mwrite_queue.sv
// Scoreboard bench for mwrite_queue: the driver queues expected writes, a monitor checks memory-side beats.
module tb_mwrite_queue;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        MEMR_MEM_W_VALID = 1'b0;
  logic [31:0] MEMR_MEM_W_ADDR = '0;
  logic [3:0]  MEMR_MEM_W_STRB = '0;
  logic [31:0] MEMR_MEM_W_DATA = '0;
  logic        MEMR_MEM_W_READY;
  logic        MEM_W_VALID;
  logic [31:0] MEM_W_ADDR;
  logic [3:0]  MEM_W_STRB;
  logic [31:0] MEM_W_DATA;
  logic        MEM_W_READY = 1'b0;
  logic [31:0] HZ_ADDR = 32'hFFFF_FFF0;
  logic        HZ_HIT;
  logic        EMPTY;
  logic [2:0]  COUNT;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;

  always #5 CLK = ~CLK;

  mwrite_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .CLK(CLK), .RST(RST),
    .MEMR_MEM_W_VALID(MEMR_MEM_W_VALID), .MEMR_MEM_W_ADDR(MEMR_MEM_W_ADDR),
    .MEMR_MEM_W_STRB(MEMR_MEM_W_STRB), .MEMR_MEM_W_DATA(MEMR_MEM_W_DATA),
    .MEMR_MEM_W_READY(MEMR_MEM_W_READY),
    .MEM_W_VALID(MEM_W_VALID), .MEM_W_ADDR(MEM_W_ADDR), .MEM_W_STRB(MEM_W_STRB),
    .MEM_W_DATA(MEM_W_DATA), .MEM_W_READY(MEM_W_READY),
    .HZ_ADDR(HZ_ADDR), .HZ_HIT(HZ_HIT), .EMPTY(EMPTY), .COUNT(COUNT)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: a beat seen valid+ready at the falling edge completes at the next rising edge.
  always @(negedge CLK) begin
    beat_t e;
    if (RST && MEM_W_VALID && MEM_W_READY) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: actual addr=%h required=no write", MEM_W_ADDR);
      end else begin
        e = exp_q.pop_front();
        chk("mon_addr", MEM_W_ADDR, e.addr);
        chk("mon_strb", 32'(MEM_W_STRB), 32'(e.strb));
        chk("mon_data", MEM_W_DATA, e.data);
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    bit    done = 1'b0;
    beat_t b;
    MEMR_MEM_W_VALID = 1'b1;
    MEMR_MEM_W_ADDR  = a;
    MEMR_MEM_W_STRB  = s;
    MEMR_MEM_W_DATA  = d;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge CLK);
      if (MEMR_MEM_W_READY) begin
        if (s != 4'b0000) begin
          b.addr = a;
          b.strb = s;
          b.data = d;
          exp_q.push_back(b);
        end
        done = 1'b1;
      end
      @(posedge CLK);
      #1;
    end
    MEMR_MEM_W_VALID = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: actual=not accepted required=accepted addr=%h", a);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 50; c++) begin
      @(negedge CLK);
      if (EMPTY) break;
    end
    chk({name, "_empty"}, 32'(EMPTY), 32'd1);
    chk({name, "_sb_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset then idle
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_valid", 32'(MEM_W_VALID), 32'd0);
    chk("rst_count", 32'(COUNT), 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    chk("idle_valid", 32'(MEM_W_VALID), 32'd0);
    chk("idle_empty", 32'(EMPTY), 32'd1);
    chk("idle_count", 32'(COUNT), 32'd0);
    chk("idle_ready", 32'(MEMR_MEM_W_READY), 32'd1);
    chk("idle_addr", MEM_W_ADDR, 32'd0);
    chk("idle_strb", 32'(MEM_W_STRB), 32'd0);
    chk("idle_data", MEM_W_DATA, 32'd0);
    chk("idle_hz", 32'(HZ_HIT), 32'd0);
    @(posedge CLK);
    #1;

    // Single store
    MEM_W_READY = 1'b1;
    send(32'h1000_0004, 4'b0011, 32'h0000_BEEF);
    chk("single_valid", 32'(MEM_W_VALID), 32'd1);
    chk("single_addr", MEM_W_ADDR, 32'h1000_0004);
    chk("single_strb", 32'(MEM_W_STRB), 32'h3);
    chk("single_data", MEM_W_DATA, 32'h0000_BEEF);
    @(posedge CLK);
    #1;
    chk("single_empty", 32'(EMPTY), 32'd1);

    // Fill and backpressure
    MEM_W_READY = 1'b0;
    for (int i = 0; i < 4; i++) send(32'(4 * i), 4'b1111, 32'hA000_0000 + 32'(i));
    chk("fill_count", 32'(COUNT), 32'd4);
    chk("fill_ready", 32'(MEMR_MEM_W_READY), 32'd0);
    fork
      send(32'h10, 4'b1111, 32'hA000_0004);
      begin
        repeat (3) @(posedge CLK);
        #2;
        chk("bp_ready", 32'(MEMR_MEM_W_READY), 32'd0);
        chk("bp_count", 32'(COUNT), 32'd4);
        chk("bp_head", MEM_W_ADDR, 32'h0);
        MEM_W_READY = 1'b1;
      end
    join
    wait_drain("fill");
    @(posedge CLK);
    #1;

    // Position rp=3 with two entries queued, then stream one-in/one-out
    MEM_W_READY = 1'b0;
    send(32'h200, 4'b0001, 32'h0000_0011);
    MEM_W_READY = 1'b1;
    wait_drain("pos");
    @(posedge CLK);
    #1;
    MEM_W_READY = 1'b0;
    send(32'h300, 4'b1100, 32'h1111_0000);
    send(32'h304, 4'b0110, 32'h0022_2200);
    chk("wrap_pre_count", 32'(COUNT), 32'd2);
    MEM_W_READY = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(32'h400 + 32'(4 * i), 4'b1111, 32'hC0DE_0000 + 32'(i));
      chk("wrap_count", 32'(COUNT), 32'd2);
    end
    wait_drain("wrap");
    @(posedge CLK);
    #1;

    // Zero strobe
    MEMR_MEM_W_VALID = 1'b1;
    MEMR_MEM_W_ADDR  = 32'h20;
    MEMR_MEM_W_STRB  = 4'b0000;
    MEMR_MEM_W_DATA  = 32'h1234_5678;
    @(negedge CLK);
    chk("zs_ready", 32'(MEMR_MEM_W_READY), 32'd1);
    @(posedge CLK);
    #1;
    MEMR_MEM_W_VALID = 1'b0;
    chk("zs_count", 32'(COUNT), 32'd0);
    @(negedge CLK);
    chk("zs_valid", 32'(MEM_W_VALID), 32'd0);
    @(posedge CLK);
    #1;

    // Hazard against stored and incoming requests
    MEM_W_READY = 1'b0;
    send(32'h100, 4'b1000, 32'h5500_0000);
    HZ_ADDR = 32'h103;
    #1;
    chk("hz_same_word", 32'(HZ_HIT), 32'd1);
    HZ_ADDR = 32'h104;
    #1;
    chk("hz_next_word", 32'(HZ_HIT), 32'd0);
    HZ_ADDR = 32'h206;
    MEMR_MEM_W_VALID = 1'b1;
    MEMR_MEM_W_ADDR  = 32'h204;
    MEMR_MEM_W_STRB  = 4'b1111;
    MEMR_MEM_W_DATA  = 32'h6666_7777;
    #1;
    chk("hz_incoming", 32'(HZ_HIT), 32'd1);
    send(32'h204, 4'b1111, 32'h6666_7777);
    chk("hz_pending_count", 32'(COUNT), 32'd2);
    chk("hz_after_enq", 32'(HZ_HIT), 32'd1);

    // Reset with two stores pending discards them
    RST = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_valid", 32'(MEM_W_VALID), 32'd0);
    chk("midrst_count", 32'(COUNT), 32'd0);
    chk("midrst_empty", 32'(EMPTY), 32'd1);
    MEM_W_READY = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    HZ_ADDR = 32'h100;
    #1;
    chk("post_rst_stale_hz", 32'(HZ_HIT), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("post_rst_valid", 32'(MEM_W_VALID), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
